// File: rtl/vc_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : vc_fifo_mem
// Description : Single-clock multi-virtual-channel FIFO buffer for a NoC
//               router input port. One memory array is statically split into
//               NUM_VC circular queues, each with its own read/write pointers
//               and full/empty flags. Read data is registered (1-cycle
//               latency).
// Ports       : clk     - clock, all logic on rising edge
//               rst_n   - asynchronous active-low reset
//               winc    - write request
//               wvc     - target VC of the write
//               wdata   - write flit
//               rinc    - read request
//               rvc     - source VC of the read
//               rdata   - read flit, valid when rvalid = 1
//               rvalid  - one cycle after an accepted read
//               full    - per-VC full flag  (bit i = VC i)
//               empty   - per-VC empty flag (bit i = VC i)
//               occ     - per-VC occupancy, only when VC_FIFO_OCC_EN defined
// Config      : VC_FIFO_OCC_EN - adds the occ output port and its logic
// Revision    : 1.0 - initial release
// ============================================================================
module vc_fifo_mem #(
    parameter int DSIZE    = 32,
    parameter int ADDRSIZE = 3,
    parameter int VC_BITS  = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              winc,
    input  logic [VC_BITS-1:0]                wvc,
    input  logic [DSIZE-1:0]                  wdata,
    input  logic                              rinc,
    input  logic [VC_BITS-1:0]                rvc,
    output logic [DSIZE-1:0]                  rdata,
    output logic                              rvalid,
    output logic [(1<<VC_BITS)-1:0]           full,
    output logic [(1<<VC_BITS)-1:0]           empty
`ifdef VC_FIFO_OCC_EN
    ,
    output logic [(1<<VC_BITS)*(ADDRSIZE+1)-1:0] occ
`endif
);

    localparam int NUM_VC    = 1 << VC_BITS;
    localparam int PTR_W     = ADDRSIZE + 1;
    localparam int MEM_DEPTH = NUM_VC * (1 << ADDRSIZE);
    localparam int MEM_AW    = VC_BITS + ADDRSIZE;

    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

    // ------------------------------------------------------------------------
    // Storage (not reset)
    // ------------------------------------------------------------------------
    logic [DSIZE-1:0] r_mem [0:MEM_DEPTH-1];

    // Pointer values of all VCs gathered for muxing by wvc/rvc
    logic [NUM_VC-1:0][PTR_W-1:0] w_wptr_all;
    logic [NUM_VC-1:0][PTR_W-1:0] w_rptr_all;

    logic              w_wr_accept;
    logic              w_rd_accept;
    logic [MEM_AW-1:0] w_waddr;
    logic [MEM_AW-1:0] w_raddr;

    // Accept decisions use the flags decoded from the current (pre-edge)
    // pointers, so a same-cycle write never bypasses into an empty VC read.
    assign w_wr_accept = winc && !full[wvc];
    assign w_rd_accept = rinc && !empty[rvc];

    assign w_waddr = {wvc, w_wptr_all[wvc][ADDRSIZE-1:0]};
    assign w_raddr = {rvc, w_rptr_all[rvc][ADDRSIZE-1:0]};

    // ------------------------------------------------------------------------
    // Per-VC pointers and flags
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
        localparam logic [VC_BITS-1:0] c_vc_id = VC_BITS'(i);

        logic [PTR_W-1:0] r_wptr;
        logic [PTR_W-1:0] r_rptr;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wptr <= '0;
            end else if (w_wr_accept && (wvc == c_vc_id)) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rptr <= '0;
            end else if (w_rd_accept && (rvc == c_vc_id)) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
        end

        assign w_wptr_all[i] = r_wptr;
        assign w_rptr_all[i] = r_rptr;

        // The extra wrap bit distinguishes full (wrap bits differ) from
        // empty (pointers identical) when the low address bits match.
        assign empty[i] = (r_wptr == r_rptr);
        assign full[i]  = (r_wptr[ADDRSIZE] != r_rptr[ADDRSIZE]) &&
                          (r_wptr[ADDRSIZE-1:0] == r_rptr[ADDRSIZE-1:0]);

`ifdef VC_FIFO_OCC_EN
        // Modulo subtraction gives 0..(1<<ADDRSIZE) thanks to the wrap bit
        assign occ[i*PTR_W +: PTR_W] = r_wptr - r_rptr;
`endif
    end

    // ------------------------------------------------------------------------
    // Memory write port
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[w_waddr] <= wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Registered read port: rdata holds its last value when no read accepted
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= w_rd_accept;
            if (w_rd_accept) begin
                rdata <= r_mem[w_raddr];
            end
        end
    end

endmodule
`default_nettype wire
